// File: rtl/varredor_sensores_pressao_pkg.sv
// Shared definitions for the pressure-sensor scanner: channel indices and FSM states.
package varredor_sensores_pressao_pkg;

  localparam int unsigned NUM_CANAIS = 7;

  localparam logic [2:0] CH_SC    = 3'd0;
  localparam logic [2:0] CH_S1    = 3'd1;
  localparam logic [2:0] CH_S2    = 3'd2;
  localparam logic [2:0] CH_S3    = 3'd3;
  localparam logic [2:0] CH_TUBSR = 3'd4;
  localparam logic [2:0] CH_TUBSS = 3'd5;
  localparam logic [2:0] CH_REA   = 3'd6;

  typedef enum logic [2:0] {
    StOcioso,
    StAssenta,
    StInicia,
    StEspera,
    StAtualiza
  } estado_e;

endpackage

// File: rtl/varredor_sensores_pressao_filtro_media_canal.sv
// Per-channel rounding average filter: first sample loads directly, later samples
// average with the held value, rounding half up.
module filtro_media_canal (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carga_i,
  input  logic [3:0] amostra_i,
  output logic [3:0] valor_o,
  output logic       preparado_o
);

  logic [3:0] valor_q, valor_d;
  logic       preparado_q, preparado_d;
  logic [4:0] soma;

  // Next value: 5-bit sum keeps the carry so (15 + 15 + 1) >> 1 stays at 15.
  always_comb begin
    soma        = {1'b0, valor_q} + {1'b0, amostra_i} + 5'd1;
    valor_d     = valor_q;
    preparado_d = preparado_q;
    if (carga_i) begin
      valor_d     = preparado_q ? soma[4:1] : amostra_i;
      preparado_d = 1'b1;
    end
  end

  // Value and primed-bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor_q     <= 4'd0;
      preparado_q <= 1'b0;
    end else begin
      valor_q     <= valor_d;
      preparado_q <= preparado_d;
    end
  end

  assign valor_o     = valor_q;
  assign preparado_o = preparado_q;

endmodule

// File: rtl/varredor_sensores_pressao.sv
// Scans seven pressure sensors through one shared ADC, filters each channel and
// flags channels whose conversion never completes.
module varredor_sensores_pressao
  import varredor_sensores_pressao_pkg::*;
#(
  parameter int unsigned SETTLE_CICLOS  = 2,
  parameter int unsigned TIMEOUT_CICLOS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       habilita,
  output logic [2:0] adc_sel,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [3:0] adc_data,
  output logic [3:0] presSC,
  output logic [3:0] presS1,
  output logic [3:0] presS2,
  output logic [3:0] presS3,
  output logic [3:0] presTubSR,
  output logic [3:0] presTubSS,
  output logic [3:0] presRea,
  output logic [6:0] falha_sensor,
  output logic       varredura_completa,
  output logic       dados_validos
);

  localparam logic [7:0] SettleFim  = 8'(SETTLE_CICLOS);
  localparam logic [7:0] TimeoutFim = 8'(TIMEOUT_CICLOS - 1);

  estado_e         estado_q, estado_d;
  logic [2:0]      ch_q, ch_d;
  logic [7:0]      cnt_q, cnt_d;  // shared by settle and timeout counting
  logic [3:0]      amostra_q, amostra_d;
  logic            valida_q, valida_d;
  logic [6:0]      falha_q, falha_d;
  logic            varre_q, varre_d;
  logic            dados_q, dados_d;

  logic [NUM_CANAIS-1:0] carga;
  logic [NUM_CANAIS-1:0] preparado;
  logic [3:0]            valor [NUM_CANAIS];

  // Next-state and per-channel load decode.
  always_comb begin
    estado_d  = estado_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    amostra_d = amostra_q;
    valida_d  = valida_q;
    falha_d   = falha_q;
    varre_d   = 1'b0;
    dados_d   = dados_q | (&preparado);
    carga     = '0;
    unique case (estado_q)
      StOcioso: begin
        if (habilita) begin
          estado_d = StAssenta;
          cnt_d    = '0;
        end
      end
      StAssenta: begin
        if (cnt_q == SettleFim) begin
          estado_d = StInicia;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StInicia: begin
        estado_d = StEspera;
        cnt_d    = '0;
      end
      StEspera: begin
        // A done strobe in the last timeout cycle still counts as a good sample.
        if (adc_done) begin
          amostra_d = adc_data;
          valida_d  = 1'b1;
          estado_d  = StAtualiza;
        end else if (cnt_q == TimeoutFim) begin
          falha_d[ch_q] = 1'b1;
          valida_d      = 1'b0;
          estado_d      = StAtualiza;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StAtualiza: begin
        if (valida_q) begin
          carga[ch_q]   = 1'b1;
          falha_d[ch_q] = 1'b0;
        end
        if (ch_q == CH_REA) begin
          ch_d    = CH_SC;
          varre_d = 1'b1;
        end else begin
          ch_d = ch_q + 3'd1;
        end
        cnt_d    = '0;
        estado_d = habilita ? StAssenta : StOcioso;
      end
      default: estado_d = StOcioso;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= StOcioso;
      ch_q      <= CH_SC;
      cnt_q     <= '0;
      amostra_q <= '0;
      valida_q  <= 1'b0;
      falha_q   <= '0;
      varre_q   <= 1'b0;
      dados_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      amostra_q <= amostra_d;
      valida_q  <= valida_d;
      falha_q   <= falha_d;
      varre_q   <= varre_d;
      dados_q   <= dados_d;
    end
  end

  for (genvar i = 0; i < NUM_CANAIS; i++) begin : g_canal
    filtro_media_canal u_filtro (
      .clk         (clk),
      .rst_n       (rst_n),
      .carga_i     (carga[i]),
      .amostra_i   (amostra_q),
      .valor_o     (valor[i]),
      .preparado_o (preparado[i])
    );
  end

  assign adc_sel            = ch_q;
  assign adc_start          = (estado_q == StInicia);
  assign falha_sensor       = falha_q;
  assign varredura_completa = varre_q;
  assign dados_validos      = dados_q;

  assign presSC    = valor[CH_SC];
  assign presS1    = valor[CH_S1];
  assign presS2    = valor[CH_S2];
  assign presS3    = valor[CH_S3];
  assign presTubSR = valor[CH_TUBSR];
  assign presTubSS = valor[CH_TUBSS];
  assign presRea   = valor[CH_REA];

endmodule

// File: tb/tb_varredor_sensores_pressao.sv
// Bench for varredor_sensores_pressao: an ADC model answers each start after a chosen
// latency and keeps a per-channel reference of the expected filtered pressures.
module tb_varredor_sensores_pressao;

  localparam int Settle  = 2;
  localparam int Timeout = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       habilita = 1'b0;
  logic       adc_done = 1'b0;
  logic [3:0] adc_data = 4'd0;
  logic [2:0] adc_sel;
  logic       adc_start;
  logic [3:0] presSC, presS1, presS2, presS3, presTubSR, presTubSS, presRea;
  logic [6:0] falha_sensor;
  logic       varredura_completa;
  logic       dados_validos;

  int checks = 0;
  int errors = 0;

  // ADC model knobs
  int lat_fixo   = 3;   // 0 selects a random latency 1..12
  int canal_mudo = -1;  // channel that never answers
  int dado_canal [7];   // -1 selects random data
  bit espurio_on = 1'b0;

  // Reference state
  int exp_pres [7];
  bit exp_prep [7];
  bit exp_falha [7];
  int n_varre = 0;

  logic [3:0] pres [7];
  assign pres[0] = presSC;
  assign pres[1] = presS1;
  assign pres[2] = presS2;
  assign pres[3] = presS3;
  assign pres[4] = presTubSR;
  assign pres[5] = presTubSS;
  assign pres[6] = presRea;

  varredor_sensores_pressao #(
    .SETTLE_CICLOS  (Settle),
    .TIMEOUT_CICLOS (Timeout)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .habilita           (habilita),
    .adc_sel            (adc_sel),
    .adc_start          (adc_start),
    .adc_done           (adc_done),
    .adc_data           (adc_data),
    .presSC             (presSC),
    .presS1             (presS1),
    .presS2             (presS2),
    .presS3             (presS3),
    .presTubSR          (presTubSR),
    .presTubSS          (presTubSS),
    .presRea            (presRea),
    .falha_sensor       (falha_sensor),
    .varredura_completa (varredura_completa),
    .dados_validos      (dados_validos)
  );

  always #5 clk = ~clk;

  // ADC model: lat = number of wait cycles the DUT spends before seeing done.
  int         pend = 0;
  int         esp_cnt = 0;
  logic [3:0] dado_pend = 4'd0;
  always @(negedge clk) begin
    int c, l, d;
    adc_done = 1'b0;
    if (!rst_n) begin
      pend    = 0;
      esp_cnt = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_done = 1'b1;
          adc_data = dado_pend;
          if (espurio_on) esp_cnt = 2;
        end
      end else if (esp_cnt > 0) begin
        esp_cnt--;
        if (esp_cnt == 0) begin
          adc_done = 1'b1;
          adc_data = 4'hF;
        end
      end
      if (adc_start === 1'b1) begin
        c = int'(adc_sel);
        l = (lat_fixo > 0) ? lat_fixo : int'($urandom_range(1, 12));
        d = (dado_canal[c] >= 0) ? dado_canal[c] : int'($urandom_range(0, 15));
        dado_pend = 4'(d);
        if (c == canal_mudo) begin
          pend         = 0;
          exp_falha[c] = 1'b1;
        end else begin
          pend = l;
          if (l <= Timeout) begin
            if (exp_prep[c]) exp_pres[c] = (exp_pres[c] + d + 1) / 2;
            else exp_pres[c] = d;
            exp_prep[c]  = 1'b1;
            exp_falha[c] = 1'b0;
          end else begin
            exp_falha[c] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) if (varredura_completa === 1'b1) n_varre++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic limpa_modelo();
    for (int i = 0; i < 7; i++) begin
      exp_pres[i]  = 0;
      exp_prep[i]  = 1'b0;
      exp_falha[i] = 1'b0;
    end
  endtask

  task automatic aplica_reset();
    @(negedge clk);
    rst_n = 1'b0;
    limpa_modelo();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic espera_start(input int limite);
    int n = 0;
    @(negedge clk);
    while (adc_start !== 1'b1 && n < limite) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (adc_start !== 1'b1) begin
      errors++;
      $display("FAIL espera_start: adc_start=%b after %0d cycles, required 1", adc_start, limite);
    end
  endtask

  task automatic espera_varredura(input int limite);
    int n = 0;
    @(negedge clk);
    while (varredura_completa !== 1'b1 && n < limite) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (varredura_completa !== 1'b1) begin
      errors++;
      $display("FAIL espera_varredura: pulse=%b after %0d cycles, required 1",
               varredura_completa, limite);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    limpa_modelo();
    repeat (3) @(negedge clk);
    checks++;
    if (adc_start !== 1'b0) begin
      errors++; $display("FAIL reset adc_start: got %b required 0", adc_start);
    end
    checks++;
    if (adc_sel !== 3'd0) begin
      errors++; $display("FAIL reset adc_sel: got %0d required 0", adc_sel);
    end
    checks++;
    if (falha_sensor !== 7'd0 || varredura_completa !== 1'b0 || dados_validos !== 1'b0) begin
      errors++;
      $display("FAIL reset status: falha=%b varre=%b dados=%b required 0 0 0",
               falha_sensor, varredura_completa, dados_validos);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (pres[i] !== 4'd0) begin
        errors++; $display("FAIL reset pres[%0d]: got %0d required 0", i, pres[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_primeira_varredura();
    int n;
    for (int i = 0; i < 7; i++) dado_canal[i] = 9;
    lat_fixo = 3;
    n_varre  = 0;
    habilita = 1'b1;
    espera_start(100);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (adc_start !== 1'b1 && n < 100);
    checks++;
    if (n != 3 + Settle + 3) begin
      errors++; $display("FAIL latencia canal: start-to-start got %0d required %0d", n, Settle + 6);
    end
    espera_varredura(400);
    habilita = 1'b0;
    checks++;
    if (dados_validos !== 1'b0) begin
      errors++; $display("FAIL dados_validos early: got %b required 0", dados_validos);
    end
    @(negedge clk);
    checks++;
    if (dados_validos !== 1'b1) begin
      errors++; $display("FAIL dados_validos rise: got %b required 1", dados_validos);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (n_varre != 1) begin
      errors++; $display("FAIL varredura pulses: got %0d required 1", n_varre);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (pres[i] !== 4'd9) begin
        errors++; $display("FAIL primeira pres[%0d]: got %0d required 9", i, pres[i]);
      end
    end
    checks++;
    if (falha_sensor !== 7'd0) begin
      errors++; $display("FAIL primeira falha: got %b required 0", falha_sensor);
    end
  endtask

  task automatic test_filtro();
    logic [3:0] e;
    aplica_reset();
    lat_fixo   = 0;
    dado_canal = '{-1, 15, 4, 0, -1, -1, -1};
    habilita   = 1'b1;
    espera_varredura(400);
    dado_canal = '{-1, 15, 9, 1, -1, -1, -1};
    espera_varredura(400);
    checks++;
    if (presS1 !== 4'd15) begin
      errors++; $display("FAIL filtro 15+15: got %0d required 15", presS1);
    end
    checks++;
    if (presS2 !== 4'd7) begin
      errors++; $display("FAIL filtro 4+9: got %0d required 7", presS2);
    end
    checks++;
    if (presS3 !== 4'd1) begin
      errors++; $display("FAIL filtro 0+1: got %0d required 1", presS3);
    end
    for (int i = 0; i < 7; i++) dado_canal[i] = -1;
    repeat (4) begin
      espera_varredura(400);
      for (int i = 0; i < 7; i++) begin
        e = 4'(exp_pres[i]);
        checks++;
        if (pres[i] !== e) begin
          errors++; $display("FAIL filtro aleatorio pres[%0d]: got %0d required %0d", i, pres[i], e);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] antes;
    logic [6:0] ef;
    int         n;
    canal_mudo = 4;
    for (int k = 0; k < 8 && adc_sel !== 3'd4; k++) espera_start(100);
    antes = presTubSR;
    n = 0;
    while (falha_sensor[4] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != Timeout + 1) begin
      errors++; $display("FAIL timeout ciclos: got %0d required %0d", n, Timeout + 1);
    end
    checks++;
    if (falha_sensor !== 7'b0010000) begin
      errors++; $display("FAIL timeout falha: got %b required 0010000", falha_sensor);
    end
    espera_start(100);
    checks++;
    if (adc_sel !== 3'd5) begin
      errors++; $display("FAIL timeout proximo canal: got %0d required 5", adc_sel);
    end
    checks++;
    if (presTubSR !== antes) begin
      errors++; $display("FAIL timeout presTubSR held: got %0d required %0d", presTubSR, antes);
    end
    canal_mudo = -1;
    espera_varredura(400);
    espera_varredura(400);
    for (int i = 0; i < 7; i++) ef[i] = exp_falha[i];
    checks++;
    if (falha_sensor !== ef || ef !== 7'd0) begin
      errors++; $display("FAIL timeout recuperacao: got %b required %b", falha_sensor, ef);
    end
  endtask

  task automatic test_limite();
    logic [3:0] e;
    lat_fixo   = Timeout;
    espurio_on = 1'b1;
    espera_varredura(500);
    espera_varredura(500);
    checks++;
    if (falha_sensor !== 7'd0) begin
      errors++; $display("FAIL limite falha: got %b required 0", falha_sensor);
    end
    for (int i = 0; i < 7; i++) begin
      e = 4'(exp_pres[i]);
      checks++;
      if (pres[i] !== e) begin
        errors++; $display("FAIL limite pres[%0d]: got %0d required %0d", i, pres[i], e);
      end
    end
    lat_fixo   = 0;
    espurio_on = 1'b0;
  endtask

  task automatic test_habilita();
    int         starts;
    logic [3:0] e;
    for (int k = 0; k < 8 && adc_sel !== 3'd2; k++) espera_start(100);
    @(negedge clk);
    habilita = 1'b0;
    starts = 0;
    repeat (30) begin
      @(negedge clk);
      if (adc_start === 1'b1) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++; $display("FAIL habilita idle starts: got %0d required 0", starts);
    end
    e = 4'(exp_pres[2]);
    checks++;
    if (presS2 !== e) begin
      errors++; $display("FAIL habilita canal 2 completes: got %0d required %0d", presS2, e);
    end
    checks++;
    if (adc_sel !== 3'd3) begin
      errors++; $display("FAIL habilita adc_sel idle: got %0d required 3", adc_sel);
    end
    habilita = 1'b1;
    espera_start(100);
    checks++;
    if (adc_sel !== 3'd3) begin
      errors++; $display("FAIL habilita resume canal: got %0d required 3", adc_sel);
    end
  endtask

  task automatic test_reset_async();
    logic [3:0] e;
    espera_start(100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (adc_start !== 1'b0 || adc_sel !== 3'd0 || falha_sensor !== 7'd0 ||
        varredura_completa !== 1'b0 || dados_validos !== 1'b0) begin
      errors++;
      $display("FAIL reset assincrono status: start=%b sel=%0d falha=%b varre=%b dados=%b required all 0",
               adc_start, adc_sel, falha_sensor, varredura_completa, dados_validos);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (pres[i] !== 4'd0) begin
        errors++; $display("FAIL reset assincrono pres[%0d]: got %0d required 0", i, pres[i]);
      end
    end
    limpa_modelo();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    espera_start(100);
    checks++;
    if (adc_sel !== 3'd0) begin
      errors++; $display("FAIL reset reinicio canal: got %0d required 0", adc_sel);
    end
    espera_varredura(400);
    checks++;
    if (dados_validos !== 1'b0) begin
      errors++; $display("FAIL reset dados_validos: got %b required 0", dados_validos);
    end
    for (int i = 0; i < 7; i++) begin
      e = 4'(exp_pres[i]);
      checks++;
      if (pres[i] !== e) begin
        errors++; $display("FAIL reset carga direta pres[%0d]: got %0d required %0d", i, pres[i], e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 7; i++) dado_canal[i] = -1;
    test_reset();
    test_primeira_varredura();
    test_filtro();
    test_timeout();
    test_limite();
    test_habilita();
    test_reset_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
